// File: rtl/spi_slave_if.sv
// Bus bundle for spi_slave: SPI pins plus the parallel transmit/receive handshake.
// Signal names carry the slave's direction; the master modport mirrors them.
interface spi_slave_if #(
    parameter int unsigned DATA_W = 8
);
    logic              i_sck;
    logic              i_cs_n;
    logic              i_mosi;
    logic              o_miso;
    logic [DATA_W-1:0] i_data;
    logic              i_load;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_busy;

    modport slave (
        input  i_sck, i_cs_n, i_mosi, i_data, i_load,
        output o_miso, o_data, o_valid, o_busy
    );

    modport master (
        output i_sck, i_cs_n, i_mosi, i_data, i_load,
        input  o_miso, o_data, o_valid, o_busy
    );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI slave with oversampled, synchronized pins, a transmit holding register
// and back-to-back frame support while chip select stays low.
module spi_slave #(
    parameter int unsigned DATA_W = 8
) (
    input logic        i_clk,
    input logic        i_rst_n,
    spi_slave_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic {StIdle, StShift} state_t;

    state_t            r_state, w_state_d;
    logic [2:0]        r_sck_sync, r_cs_sync, r_mosi_sync;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rx, r_tx, r_hold, r_data;
    logic              r_valid;
    logic              w_sck_rise, w_sck_fall, w_cs_fall, w_cs_s, w_mosi_s;
    logic              w_active, w_reload, w_last_rise;
    logic [DATA_W-1:0] w_tx_src;
    logic              w_busy, w_miso;
    logic              w_unused;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sck_sync  <= 3'b000;
            r_cs_sync   <= 3'b111;
            r_mosi_sync <= 3'b000;
        end else begin
            r_sck_sync  <= {r_sck_sync[1:0], bus.i_sck};
            r_cs_sync   <= {r_cs_sync[1:0], bus.i_cs_n};
            r_mosi_sync <= {r_mosi_sync[1:0], bus.i_mosi};
        end
    end

    assign w_sck_rise = ~r_sck_sync[2] & r_sck_sync[1];
    assign w_sck_fall = r_sck_sync[2] & ~r_sck_sync[1];
    assign w_cs_fall  = r_cs_sync[2] & ~r_cs_sync[1];
    assign w_cs_s     = r_cs_sync[1];
    assign w_mosi_s   = r_mosi_sync[1];
    // Third mosi stage exists only to match the other pin chains.
    assign w_unused   = r_mosi_sync[2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_cs_fall) w_state_d = StShift;
            StShift: if (w_cs_s)    w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_busy = (r_state == StShift);
        w_miso = w_busy ? r_tx[DATA_W-1] : 1'b0;
    end

    assign w_active    = (r_state == StShift) && !w_cs_s;
    assign w_last_rise = w_active && w_sck_rise && (r_cnt == CNT_W'(DATA_W - 1));
    // Counter parks at DATA_W after the last rise so the next fall reloads instead of shifting.
    assign w_reload    = ((r_state == StIdle) && w_cs_fall) ||
                         (w_active && w_sck_fall && (r_cnt == CNT_W'(DATA_W)));
    assign w_tx_src    = bus.i_load ? bus.i_data : r_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_rx    <= '0;
            r_tx    <= '0;
            r_hold  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bus.i_load) begin
                r_hold <= bus.i_data;
            end
            if (w_reload) begin
                r_tx  <= w_tx_src;
                r_cnt <= '0;
            end else if (w_active && w_sck_fall) begin
                r_tx <= {r_tx[DATA_W-2:0], 1'b0};
            end
            if (w_active && w_sck_rise) begin
                r_rx  <= {r_rx[DATA_W-2:0], w_mosi_s};
                r_cnt <= r_cnt + 1'b1;
                if (w_last_rise) begin
                    r_data  <= {r_rx[DATA_W-2:0], w_mosi_s};
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.o_data  = r_data;
    assign bus.o_valid = r_valid;
    assign bus.o_busy  = w_busy;
    assign bus.o_miso  = w_miso;
endmodule

// File: tb/tb_spi_slave.sv
// Directed plus randomized bench for spi_slave; expected words come from a
// frame-level model (holding value at frame start, queue of completed MOSI words).
module tb_spi_slave;
    localparam int unsigned DW   = 8;
    localparam int          HALF = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_if #(.DATA_W(DW)) bus ();

    spi_slave #(.DATA_W(DW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int        n_vec = 0;
    int        n_err = 0;
    logic [7:0] m_hold = 8'h00;
    logic [7:0] m_last = 8'h00;
    logic [7:0] q_exp[$];
    logic [7:0] q_got[$];
    logic       prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Collect every received word and flag any pulse longer than one cycle.
    always @(negedge clk) begin
        if (bus.o_valid) begin
            q_got.push_back(bus.o_data);
            check("valid_width", 32'(prev_valid), 32'd0);
        end
        prev_valid = bus.o_valid;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] d);
        @(negedge clk);
        bus.i_data = d;
        bus.i_load = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        m_hold = d;
    endtask

    task automatic shift_bits(input logic [7:0] mo, input int first, input int last,
                              input logic [7:0] exp_tx, input string tag);
        for (int i = first; i < last; i++) begin
            bus.i_mosi = mo[7-i];
            wait_clk(HALF);
            check({tag, "_miso"}, 32'(bus.o_miso), 32'(exp_tx[7-i]));
            check({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
            bus.i_sck = 1'b1;
            wait_clk(HALF);
            bus.i_sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] mo, input string tag);
        logic [7:0] tx;
        tx = m_hold;
        bus.i_cs_n = 1'b0;
        wait_clk(HALF);
        shift_bits(mo, 0, 8, tx, tag);
        wait_clk(HALF);
        bus.i_cs_n = 1'b1;
        wait_clk(HALF);
        q_exp.push_back(mo);
        m_last = mo;
    endtask

    task automatic check_rx(input string tag);
        wait_clk(4);
        check({tag, "_nvalid"}, 32'(q_got.size()), 32'(q_exp.size()));
        for (int i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
            check({tag, "_rxword"}, 32'(q_got[i]), 32'(q_exp[i]));
        end
        check({tag, "_odata"}, 32'(bus.o_data), 32'(m_last));
        q_got.delete();
        q_exp.delete();
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        check({tag, "_miso"}, 32'(bus.o_miso), 32'd0);
    endtask

    initial begin
        logic [7:0] tx0;
        logic [7:0] mo;
        int         nf;

        bus.i_sck  = 1'b0;
        bus.i_cs_n = 1'b1;
        bus.i_mosi = 1'b0;
        bus.i_data = '0;
        bus.i_load = 1'b0;
        wait_clk(3);
        check("rst_odata", 32'(bus.o_data), 32'd0);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check_idle_outs("rst");
        rst_n = 1'b1;
        wait_clk(4);

        // Basic frame.
        load(8'hA5);
        frame(8'h3C, "basic");
        check_rx("basic");

        // Back-to-back frames with a reload during the first.
        tx0 = m_hold;
        bus.i_cs_n = 1'b0;
        wait_clk(HALF);
        shift_bits(8'h12, 0, 4, tx0, "b2b0");
        load(8'h77);
        shift_bits(8'h12, 4, 8, tx0, "b2b0");
        shift_bits(8'h34, 0, 8, m_hold, "b2b1");
        wait_clk(HALF);
        bus.i_cs_n = 1'b1;
        wait_clk(HALF);
        q_exp.push_back(8'h12);
        q_exp.push_back(8'h34);
        m_last = 8'h34;
        check_rx("b2b");

        // Abort after five bits, then a full frame.
        bus.i_cs_n = 1'b0;
        wait_clk(HALF);
        shift_bits(8'($urandom), 0, 5, m_hold, "abort");
        wait_clk(HALF);
        bus.i_cs_n = 1'b1;
        wait_clk(HALF);
        check_idle_outs("abort");
        check_rx("abort");
        frame(8'($urandom), "after_abort");
        check_rx("after_abort");

        // Retransmit of an unreloaded holding word.
        load(8'hC3);
        frame(8'($urandom), "retx0");
        frame(8'($urandom), "retx1");
        check_rx("retx");

        // Load coincident with the tx_shift load at frame start takes the new word.
        @(negedge clk);
        bus.i_cs_n = 1'b0;
        wait_clk(2);
        bus.i_data = 8'h5E;
        bus.i_load = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        m_hold = 8'h5E;
        wait_clk(HALF);
        mo = 8'($urandom);
        shift_bits(mo, 0, 8, 8'h5E, "bypass");
        wait_clk(HALF);
        bus.i_cs_n = 1'b1;
        wait_clk(HALF);
        q_exp.push_back(mo);
        m_last = mo;
        check_rx("bypass");

        // Reset mid-frame.
        bus.i_cs_n = 1'b0;
        wait_clk(HALF);
        shift_bits(8'($urandom), 0, 3, m_hold, "rstmid");
        wait_clk(2);
        rst_n = 1'b0;
        #1;
        check("rstmid_odata", 32'(bus.o_data), 32'd0);
        check("rstmid_valid", 32'(bus.o_valid), 32'd0);
        check_idle_outs("rstmid");
        bus.i_cs_n = 1'b1;
        m_hold = 8'h00;
        m_last = 8'h00;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(HALF);
        check_rx("rstmid");
        frame(8'hFF, "post_rst");
        check_rx("post_rst");

        // sck noise with cs_n high.
        for (int i = 0; i < 10; i++) begin
            bus.i_sck = 1'b1;
            wait_clk(HALF);
            check_idle_outs("noise_hi");
            bus.i_sck = 1'b0;
            wait_clk(HALF);
            check_idle_outs("noise_lo");
        end
        check_rx("noise");

        // Random frame bursts with optional trailing abort.
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(1) == 1) load(8'($urandom));
            nf = int'($urandom_range(3, 1));
            bus.i_cs_n = 1'b0;
            wait_clk(HALF);
            for (int f = 0; f < nf; f++) begin
                mo = 8'($urandom);
                shift_bits(mo, 0, 8, m_hold, "rand");
                q_exp.push_back(mo);
                m_last = mo;
            end
            if ($urandom_range(3) == 0) begin
                shift_bits(8'($urandom), 0, int'($urandom_range(7, 1)), m_hold, "rand_abort");
            end
            wait_clk(HALF);
            bus.i_cs_n = 1'b1;
            wait_clk(HALF);
            check_idle_outs("rand_idle");
            check_rx("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
